floating_point_subtractor: RTL and testbench

- Multi-cycle IEEE 754 single-precision subtractor: result = a - b.
- Companion to the single-cycle adder in the FP datapath, implementing the inverse operation.
- Unlike the adder, it fully normalises the result: one left-shift per cycle until the leading 1 is found or the denormal floor is reached.
- Valid/ready handshakes on both input and output, so it sits directly between the operand queue and the result writeback.

---
 rtl/floating_point_subtractor.sv | 152 +++++++++++++++
 tb/tb_floating_point_subtractor.sv | 136 +++++++++++++
 2 files changed

// File: rtl/floating_point_subtractor.sv
// Multi-cycle IEEE 754 single-precision subtractor (result = a - b) with valid/ready handshakes.
// Define FP_SPECIAL_EN to enable NaN/infinity handling; otherwise exponent 255 is ordinary.
module floating_point_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_invalid,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign_a, sign_b, sign_r;
    logic [7:0]  exp_a, exp_b, exp_r;
    logic [23:0] mant_a, mant_b;
    logic [24:0] sum_r;
    logic [8:0]  exp_inc;
    logic        norm_done;

    logic             special_hit;
    logic             special_invalid;
    logic [WIDTH-1:0] special_result;

`ifdef FP_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    assign special_hit     = a_nan | b_nan | a_inf | b_inf;
    // inf - inf is invalid only when both infinities share a sign
    assign special_invalid = a_nan | b_nan | (a_inf & b_inf & (a[31] == b[31]));
    assign special_result  = special_invalid ? 32'h7FC0_0000 :
                             a_inf ? {a[31], 8'hFF, 23'd0} : {~b[31], 8'hFF, 23'd0};
`else
    assign special_hit     = 1'b0;
    assign special_invalid = 1'b0;
    assign special_result  = '0;
`endif

    assign exp_inc   = {1'b0, exp_r} + 9'd1;
    assign norm_done = (sum_r == '0) || sum_r[24] || sum_r[23] || (exp_r == 8'd1);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special_hit ? DONE : ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            sign_r       <= 1'b0;
            exp_a        <= '0;
            exp_b        <= '0;
            exp_r        <= '0;
            mant_a       <= '0;
            mant_b       <= '0;
            sum_r        <= '0;
            result       <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtraction is addition with the subtrahend's sign flipped
                    sign_a       <= a[31];
                    sign_b       <= ~b[31];
                    exp_a        <= (a[30:23] == '0) ? 8'd1 : a[30:23];
                    exp_b        <= (b[30:23] == '0) ? 8'd1 : b[30:23];
                    mant_a       <= {(a[30:23] != '0), a[22:0]};
                    mant_b       <= {(b[30:23] != '0), b[22:0]};
                    result       <= special_hit ? special_result : '0;
                    out_zero     <= 1'b0;
                    out_overflow <= 1'b0;
                    out_invalid  <= special_invalid;
                end
                ALIGN: begin
                    if (exp_a >= exp_b) begin
                        exp_r  <= exp_a;
                        mant_b <= mant_b >> (exp_a - exp_b);
                    end else begin
                        exp_r  <= exp_b;
                        mant_a <= mant_a >> (exp_b - exp_a);
                    end
                end
                ADD: begin
                    if (sign_a == sign_b) begin
                        sum_r  <= {1'b0, mant_a} + {1'b0, mant_b};
                        sign_r <= sign_a;
                    end else if (mant_a >= mant_b) begin
                        sum_r  <= {1'b0, mant_a} - {1'b0, mant_b};
                        sign_r <= sign_a;
                    end else begin
                        sum_r  <= {1'b0, mant_b} - {1'b0, mant_a};
                        sign_r <= sign_b;
                    end
                end
                NORM: begin
                    if (sum_r == '0) begin
                        result   <= '0;
                        out_zero <= 1'b1;
                    end else if (sum_r[24]) begin
                        if (exp_inc >= 9'd255) begin
                            result       <= {sign_r, 8'hFF, 23'd0};
                            out_overflow <= 1'b1;
                        end else begin
                            result <= {sign_r, exp_inc[7:0], sum_r[23:1]};
                        end
                    end else if (sum_r[23]) begin
                        result <= {sign_r, exp_r, sum_r[22:0]};
                    end else if (exp_r == 8'd1) begin
                        result <= {sign_r, 8'h00, sum_r[22:0]};
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_subtractor.sv
// Directed self-checking bench for floating_point_subtractor using immediate assertions.
module tb_floating_point_subtractor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_invalid;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    floating_point_subtractor #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_invalid(out_invalid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launches one operation and waits for out_valid; lat counts the accept edge as edge 1
    task automatic launch(input logic [31:0] aa, input logic [31:0] bb, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [31:0] exp_r, input logic [2:0] exp_flags,
                           input int exp_lat);
        int lat;
        launch(aa, bb, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_r);
        check({tag, " flags"}, {29'd0, out_zero, out_overflow, out_invalid}, {29'd0, exp_flags});
        handshake();
        check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        #3;
        check("reset result", result, 32'h0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset flags", {29'd0, out_zero, out_overflow, out_invalid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // flags are {zero, overflow, invalid}
        run_vec("3-1",       32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);
        run_vec("1-1",       32'h3F800000, 32'h3F800000, 32'h00000000, 3'b100, 4);
        run_vec("1-(-1)",    32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000, 4);
        run_vec("1-0.99",    32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 3'b000, 27);
        run_vec("max-(-max)",32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010, 4);
        run_vec("denorm",    32'h00000002, 32'h00000001, 32'h00000001, 3'b000, 4);
        run_vec("1-3",       32'h3F800000, 32'h40400000, 32'hC0000000, 3'b000, 4);

        // Hold DONE with back-pressure; in_valid pulses must not be taken
        launch(32'h40400000, 32'h3F800000, lat);
        check("hold latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'h41200000; b = 32'h3F800000;
            @(posedge clk); #1;
            check("hold result", result, 32'h40000000);
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        check("post-hold in_ready", {31'd0, in_ready}, 32'd1);
        check("post-hold out_valid", {31'd0, out_valid}, 32'd0);

        // Reset asynchronously while the long normalisation is in progress
        a = 32'h3F800000; b = 32'h3F7FFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid-reset busy", {31'd0, busy}, 32'd0);
        check("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
        check("mid-reset result", result, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec("after reset 3-1", 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);

`ifdef FP_SPECIAL_EN
        run_vec("inf-inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 1);
        run_vec("1-inf",      32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 1);
        run_vec("nan-1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1);
        run_vec("post-special 3-1", 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
